load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store unit for the 32-bit processor's memory stage. Accepts one access from the control unit, runs a req/ack handshake with data memory, and returns load data that feeds the data input (`Inp2_`) of the writeback 2:1 mux; the control unit's mem-to-reg select chooses it over the ALU result. It stalls the core via `busy_` until the access completes.

## Interface

Parameters:
- `TIMEOUT`, default 255: maximum ACCESS cycles without `mem_ack_` before abort. Range 1..255.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start_`  in  1: access request. Sampled only in IDLE.
- `op_`  in  2: operation.
  - 00 LW
  - 01 SW
  - 10 LB (sign-extended)
  - 11 SB
- `addr_`  in  32: byte address from the ALU.
- `wdata_`  in  32: store data. SB uses bits [7:0].
- `busy_`  out  1: high from the cycle after `start_` is accepted until `done_` has been asserted.
- `done_`  out  1: one-cycle completion pulse.
- `err_`  out  1: valid only with `done_`. Flags a misaligned word access or a timeout.
- `rdata_`  out  32: load result, to the writeback mux.
- `mem_req_`  out  1: memory request.
- `mem_we_`  out  1: 1 = write.
- `mem_addr_`  out  32: word-aligned address, `{addr_[31:2],2'b00}`.
- `mem_be_`  out  4: byte enables.
- `mem_wdata_`  out  32: write data.
- `mem_rdata_`  in  32: read data. Valid in the cycle `mem_ack_` is high.
- `mem_ack_`  in  1: access complete.

## Operation

- State machine: IDLE, ACCESS, DONE.
  - IDLE → ACCESS on `start_` with an aligned address. `op_`, `addr_` and `wdata_` are latched.
  - IDLE → DONE on `start_` with LW/SW and `addr_[1:0]` != 0. No memory request is issued; `err_` is set.
  - ACCESS → DONE on `mem_ack_`, or when the wait counter reaches `TIMEOUT` (`err_` is set).
  - DONE → IDLE unconditionally.
- Byte lanes are little-endian.
  - SB: `mem_be_ = 4'b0001 << addr[1:0]`, and `wdata[7:0]` is replicated on all four lanes.
  - SW: `mem_be_ = 4'b1111`.
  - Loads: `mem_be_ = 4'b1111`, `mem_we_ = 0`.
- `rdata_` is registered when `mem_ack_` is sampled on a load.
  - LW: the full word.
  - LB: byte `addr[1:0]`, sign-extended from bit 7.
  - Stores, errors and timeouts leave `rdata_` unchanged. It holds its value until the next successful load.
- `mem_req_`, `mem_we_`, `mem_addr_`, `mem_be_` and `mem_wdata_` are registered and stay stable for the whole of ACCESS.
- Wait counter: 8 bits, cleared on entering ACCESS, incremented each ACCESS cycle without an ack.
- Boundary conditions:
  - `start_` while not IDLE: ignored, with no queuing.
  - `mem_ack_` outside ACCESS: ignored.
  - `mem_ack_` in the same cycle the counter hits `TIMEOUT`: the ack wins, `err_` = 0.
  - `rst` mid-access: state returns to IDLE, `mem_req_` is low on the next cycle, and no `done_` is produced.

## Timing

- Reset values:
  - state IDLE
  - `busy_`, `done_`, `err_`, `mem_req_`, `mem_we_` = 0
  - `mem_addr_`, `mem_wdata_`, `rdata_` = 0
  - `mem_be_` = 4'b0000
- Accepted access:
  - `start_` high at cycle N.
  - `mem_req_` and `busy_` high at N+1.
  - `mem_ack_` at cycle N+1+k (k ≥ 0).
  - `done_` high at N+2+k, with `rdata_` valid in that same cycle.
  - Minimum latency is 2 cycles.
- Misaligned access: `start_` at N gives `done_`=1 and `err_`=1 at N+1, with `mem_req_` never asserted.
- Timeout: with no ack, `mem_req_` drops and `done_`/`err_` assert `TIMEOUT`+1 cycles after `mem_req_` rose.
- Back-to-back: the earliest next accepted `start_` is the cycle after `done_`.

## Structure

- Package `lsu_pkg` holds:
  - the `op_` encodings (OP_LW, OP_SW, OP_LB, OP_SB);
  - the state enum;
  - the default `TIMEOUT`.
- One combinational sub-module, `lsu_byte_lane`. It generates `mem_be_` and the replicated write data from `op`/`addr[1:0]`, and extracts and sign-extends load bytes. It is instantiated once.

## Test plan

- LW at `addr_`=0x100, with memory acking after 2 waits and returning 0xDEADBEEF: `done_` 4 cycles after `start_`, `rdata_`=0xDEADBEEF, `err_`=0, `mem_be_`=4'b1111.
- SB at `addr_`=0x203, `wdata_`=0x000000A5: `mem_addr_`=0x200, `mem_be_`=4'b1000, `mem_wdata_`=0xA5A5A5A5, `mem_we_`=1; `rdata_` unchanged.
- LB at `addr_`=0x401 with `mem_rdata_`=0x00008000 → `rdata_`=0xFFFFFF80; at 0x402 with `mem_rdata_`=0x007F0000 → `rdata_`=0x0000007F.
- LW at `addr_`=0x102 → `done_`=`err_`=1 one cycle after `start_`, `mem_req_` never high. With `TIMEOUT`=4 and no ack → `err_` with `done_`, `mem_req_` low afterwards.
- `rst` asserted 1 cycle into ACCESS → `mem_req_`=0 next cycle, no `done_`. A `start_` pulsed while busy is ignored, giving exactly one `done_` per accepted access.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states and
// the default memory-ack timeout.
package lsu_pkg;

  localparam logic [1:0] OP_LW = 2'b00;
  localparam logic [1:0] OP_SW = 2'b01;
  localparam logic [1:0] OP_LB = 2'b10;
  localparam logic [1:0] OP_SB = 2'b11;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } lsu_state_e;

  function automatic logic is_store(input logic [1:0] op);
    return (op == OP_SW) || (op == OP_SB);
  endfunction

  function automatic logic is_word(input logic [1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian byte-lane steering: store byte enables and lane replication,
// plus load byte extraction with sign extension.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  st_op,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  input  logic [1:0]  ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_result
);

  logic [7:0] ld_byte;

  always_comb begin
    be       = 4'b1111;
    st_lanes = st_data;
    if (st_op == OP_SB) begin
      be       = 4'b0001 << st_off;
      st_lanes = {4{st_data[7:0]}};
    end
  end

  always_comb begin
    ld_byte = ld_word[7:0];
    unique case (ld_off)
      2'd0: ld_byte = ld_word[7:0];
      2'd1: ld_byte = ld_word[15:8];
      2'd2: ld_byte = ld_word[23:16];
      2'd3: ld_byte = ld_word[31:24];
      default: ld_byte = ld_word[7:0];
    endcase
  end

  assign ld_result = (ld_op == OP_LB) ? {{24{ld_byte[7]}}, ld_byte} : ld_word;

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one access at a time over a req/ack memory
// handshake, with misalignment and ack-timeout error reporting.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_,
  input  logic [1:0]  op_,
  input  logic [31:0] addr_,
  input  logic [31:0] wdata_,
  output logic        busy_,
  output logic        done_,
  output logic        err_,
  output logic [31:0] rdata_,
  output logic        mem_req_,
  output logic        mem_we_,
  output logic [31:0] mem_addr_,
  output logic [3:0]  mem_be_,
  output logic [31:0] mem_wdata_,
  input  logic [31:0] mem_rdata_,
  input  logic        mem_ack_
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  lsu_state_e  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_load;
  logic        misaligned;

  // Store steering uses the incoming request; load extraction uses the
  // offset captured at accept time.
  lsu_byte_lane u_byte_lane (
    .st_op     (op_),
    .st_off    (addr_[1:0]),
    .st_data   (wdata_),
    .ld_op     (op_q),
    .ld_off    (off_q),
    .ld_word   (mem_rdata_),
    .be        (lane_be),
    .st_lanes  (lane_wdata),
    .ld_result (lane_load)
  );

  assign misaligned = is_word(op_) && (addr_[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    req_d   = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (start_) begin
          if (misaligned) begin
            state_d = StDone;
            err_d   = 1'b1;
          end else begin
            state_d = StAccess;
            err_d   = 1'b0;
            cnt_d   = 8'd0;
            op_d    = op_;
            off_d   = addr_[1:0];
            req_d   = 1'b1;
            we_d    = is_store(op_);
            addr_d  = {addr_[31:2], 2'b00};
            be_d    = lane_be;
            wdata_d = lane_wdata;
          end
        end
      end
      StAccess: begin
        // An ack in the same cycle the counter expires still completes cleanly.
        if (mem_ack_) begin
          state_d = StDone;
          err_d   = 1'b0;
          if (!is_store(op_q)) begin
            rdata_d = lane_load;
          end
        end else if (cnt_q == TimeoutCnt) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          req_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OP_LW;
      off_q   <= 2'b00;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'b0000;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy_      = (state_q != StIdle);
  assign done_      = (state_q == StDone);
  assign err_       = done_ & err_q;
  assign rdata_     = rdata_q;
  assign mem_req_   = req_q;
  assign mem_we_    = we_q;
  assign mem_addr_  = addr_q;
  assign mem_be_    = be_q;
  assign mem_wdata_ = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// accesses against a transaction-level reference model.
module tb_load_store_unit;

  localparam int unsigned TO = 4;
  localparam logic [1:0] LW = 2'b00;
  localparam logic [1:0] SW = 2'b01;
  localparam logic [1:0] LB = 2'b10;
  localparam logic [1:0] SB = 2'b11;

  logic        clk;
  logic        rst;
  logic        start_;
  logic [1:0]  op_;
  logic [31:0] addr_;
  logic [31:0] wdata_;
  logic        busy_;
  logic        done_;
  logic        err_;
  logic [31:0] rdata_;
  logic        mem_req_;
  logic        mem_we_;
  logic [31:0] mem_addr_;
  logic [3:0]  mem_be_;
  logic [31:0] mem_wdata_;
  logic [31:0] mem_rdata_;
  logic        mem_ack_;

  int          n_cmp;
  int          n_err;
  logic [31:0] exp_rdata;

  load_store_unit #(
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_     (start_),
    .op_        (op_),
    .addr_      (addr_),
    .wdata_     (wdata_),
    .busy_      (busy_),
    .done_      (done_),
    .err_       (err_),
    .rdata_     (rdata_),
    .mem_req_   (mem_req_),
    .mem_we_    (mem_we_),
    .mem_addr_  (mem_addr_),
    .mem_be_    (mem_be_),
    .mem_wdata_ (mem_wdata_),
    .mem_rdata_ (mem_rdata_),
    .mem_ack_   (mem_ack_)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_be(input logic [1:0] op, input logic [31:0] a);
    if (op == SB) return 4'(1 << (a % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] op, input logic [31:0] w);
    if (op == SB) return (w % 256) * 32'h0101_0101;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] word);
    int unsigned b;
    if (op == LW) return word;
    b = (word >> (8 * (a % 4))) % 256;
    if (b >= 128) return 32'(int'(b) - 256);
    return 32'(b);
  endfunction

  // Drives one access starting in the current cycle; k is the number of wait
  // cycles before ack (-1 = never acks). Returns in the first idle cycle.
  task automatic run_access(input string tag, input logic [1:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input int k, input logic [31:0] word);
    bit          store;
    bit          mis;
    bit          acked;
    int          lat;
    logic [3:0]  e_be;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    store  = (op == SW) || (op == SB);
    mis    = (op == LW || op == SW) && (addr % 4 != 0);
    acked  = !mis && (k >= 0) && (k <= int'(TO));
    lat    = mis ? 1 : (acked ? k + 2 : int'(TO) + 2);
    e_be   = model_be(op, addr);
    e_addr = addr - (addr % 4);
    e_wd   = model_wdata(op, wdata);

    start_   = 1'b1;
    op_      = op;
    addr_    = addr;
    wdata_   = wdata;
    mem_ack_ = 1'b0;
    for (int c = 1; c <= lat + 1; c++) begin
      @(posedge clk);
      #1;
      start_     = 1'b0;
      mem_ack_   = 1'b0;
      mem_rdata_ = $urandom;
      if (c < lat) begin
        check_eq({tag, ".req"}, 32'(mem_req_), 32'd1);
        check_eq({tag, ".busy"}, 32'(busy_), 32'd1);
        check_eq({tag, ".done_early"}, 32'(done_), 32'd0);
        check_eq({tag, ".addr"}, mem_addr_, e_addr);
        check_eq({tag, ".be"}, 32'(mem_be_), 32'(e_be));
        check_eq({tag, ".we"}, 32'(mem_we_), 32'(store));
        if (store) check_eq({tag, ".wdata"}, mem_wdata_, e_wd);
        check_eq({tag, ".rdata_hold"}, rdata_, exp_rdata);
      end else if (c == lat) begin
        if (acked && !store) exp_rdata = model_load(op, addr, word);
        check_eq({tag, ".done"}, 32'(done_), 32'd1);
        check_eq({tag, ".err"}, 32'(err_), 32'(mis || !acked));
        check_eq({tag, ".req_off"}, 32'(mem_req_), 32'd0);
        check_eq({tag, ".rdata"}, rdata_, exp_rdata);
      end else begin
        check_eq({tag, ".done_once"}, 32'(done_), 32'd0);
        check_eq({tag, ".idle"}, 32'(busy_), 32'd0);
        check_eq({tag, ".req_idle"}, 32'(mem_req_), 32'd0);
      end
      if (c <= lat) begin
        if (acked && c == k + 1) begin
          mem_ack_   = 1'b1;
          mem_rdata_ = word;
        end else if (c == lat && $urandom_range(0, 1) == 1) begin
          mem_ack_ = 1'b1;
        end
        if ($urandom_range(0, 3) == 0) begin
          start_ = 1'b1;
          op_    = 2'($urandom);
          addr_  = $urandom;
          wdata_ = $urandom;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [1:0]  op;
    logic [1:0]  off;
    int          k;

    n_cmp      = 0;
    n_err      = 0;
    exp_rdata  = 32'd0;
    rst        = 1'b1;
    start_     = 1'b0;
    op_        = LW;
    addr_      = 32'd0;
    wdata_     = 32'd0;
    mem_rdata_ = 32'd0;
    mem_ack_   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.busy", 32'(busy_), 32'd0);
    check_eq("rst.done", 32'(done_), 32'd0);
    check_eq("rst.err", 32'(err_), 32'd0);
    check_eq("rst.req", 32'(mem_req_), 32'd0);
    check_eq("rst.we", 32'(mem_we_), 32'd0);
    check_eq("rst.addr", mem_addr_, 32'd0);
    check_eq("rst.wdata", mem_wdata_, 32'd0);
    check_eq("rst.rdata", rdata_, 32'd0);
    check_eq("rst.be", 32'(mem_be_), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_access("lw100", LW, 32'h0000_0100, 32'd0, 2, 32'hDEAD_BEEF);
    run_access("sb203", SB, 32'h0000_0203, 32'h0000_00A5, 0, 32'h1234_5678);
    run_access("lb401", LB, 32'h0000_0401, 32'd0, 1, 32'h0000_8000);
    run_access("lb402", LB, 32'h0000_0402, 32'd0, 0, 32'h007F_0000);
    run_access("lw102", LW, 32'h0000_0102, 32'd0, 0, 32'h5555_5555);
    run_access("sw301", SW, 32'h0000_0301, 32'hCAFE_F00D, 0, 32'd0);
    run_access("tmo", LW, 32'h0000_0300, 32'd0, -1, 32'd0);
    run_access("ackwin", LW, 32'h0000_0500, 32'd0, int'(TO), 32'h0BAD_F00D);

    // Reset one cycle into ACCESS, with strays acks while idle afterwards.
    start_ = 1'b1;
    op_    = LW;
    addr_  = 32'h0000_0600;
    @(posedge clk);
    #1;
    start_ = 1'b0;
    check_eq("rstmid.req_up", 32'(mem_req_), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    exp_rdata = 32'd0;
    check_eq("rstmid.req", 32'(mem_req_), 32'd0);
    check_eq("rstmid.done", 32'(done_), 32'd0);
    check_eq("rstmid.busy", 32'(busy_), 32'd0);
    for (int i = 0; i < 3; i++) begin
      mem_ack_   = 1'b1;
      mem_rdata_ = $urandom;
      @(posedge clk);
      #1;
      check_eq("rstmid.no_done", 32'(done_), 32'd0);
      check_eq("rstmid.rdata", rdata_, 32'd0);
    end
    mem_ack_ = 1'b0;

    for (int i = 0; i < 200; i++) begin
      op  = 2'($urandom_range(0, 3));
      r   = $urandom;
      off = 2'($urandom_range(0, 3));
      if ((op == LW || op == SW) && $urandom_range(0, 3) != 0) off = 2'b00;
      k   = $urandom_range(0, TO + 1);
      if (k == int'(TO) + 1) k = -1;
      run_access("rnd", op, {r[31:2], off}, $urandom, k, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
